sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like bus master port between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage).
- Sequences each transfer through an address phase and a data phase.
- Returns a one-cycle completion pulse to the owning requester.
- Raises stall requests that feed the pipeline stall controller (`StallBus` generation).

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width; must be 32 (strobe is 4 bits).

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held high with stable inst_addr until inst_ok
- inst_addr  in  ADDR_W  fetch address (pc)
- inst_rdata  out  DATA_W  fetched word; valid when inst_ok=1
- inst_ok  out  1  one-cycle completion pulse to IF
- data_req  in  1  load/store request; held with stable fields until data_ok
- data_wr  in  1  1=store, 0=load
- data_wen  in  4  byte strobes for stores
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data; valid when data_ok=1
- data_ok  out  1  one-cycle completion pulse to MEM
- bus_req  out  1  bus address-phase request
- bus_wr  out  1  bus write flag
- bus_wstrb  out  4  bus byte strobes; 0 for reads
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok  in  1  slave accepted address this cycle
- bus_data_ok  in  1  slave returns read data / write ack this cycle
- bus_rdata  in  DATA_W  slave read data
- stallreq_if  out  1  IF must hold pc
- stallreq_mem  out  1  MEM and earlier stages must hold

Behaviour:
- Reset (resetn=0, async): state=IDLE, owner=INST. bus_req, bus_wr, bus_wstrb, inst_ok, data_ok are 0. bus_addr, bus_wdata, inst_rdata, data_rdata are 0.
- States and transitions:
  - IDLE: grant to data if data_req, else to inst if inst_req, else stay. On grant, latch owner, wr, strobe, addr and wdata into bus registers; go to ADDR.
  - ADDR: bus_req=1 with latched fields. If bus_addr_ok, go to WAIT (bus_req drops next cycle). Otherwise hold all fields unchanged.
  - WAIT: bus_req=0. If bus_data_ok, capture bus_rdata into the owner's rdata register, pulse the owner's ok next cycle, and go to IDLE.
- Latency: grant-to-bus_req is 1 cycle. With zero-wait slave (addr_ok same cycle as req, data_ok next cycle), inst_ok/data_ok is asserted 3 cycles after the request is first seen in IDLE.
- bus_data_ok while in IDLE or ADDR: ignored, no state change. Slave never returns data in the same cycle as addr_ok.
- Store: wr=1, wstrb=data_wen; data_ok pulses; data_rdata keeps its previous value.
- Load: wstrb=0 regardless of data_wen.
- inst_ok/data_ok are high exactly one cycle per transfer. The requester may drop req in that same cycle.
- A new grant happens no earlier than the cycle after the ok pulse. This prevents an ok-cycle req from being double-served.
- stallreq_if = inst_req & ~inst_ok.
- stallreq_mem = data_req & ~data_ok.
- Both stall outputs are combinational and have no reset dependency beyond ok.
- Simultaneous inst_req and data_req in IDLE: data granted first. Inst is granted on the next IDLE after data_ok.
- Requester drops req mid-transfer (flush): the transfer completes on the bus and the ok pulse is still issued; the requester ignores it.
- Reset mid-transfer: FSM returns to IDLE immediately. The slave is reset by the same resetn.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined: a 1-bit streak flag is set when data wins a grant while inst_req is pending. While set, the next IDLE with both requests grants inst; the flag clears on any inst grant. Fetch is never starved beyond one data transfer.
- Undefined: strict data priority as above; no flag register.

Decomposition:
- Shared package (alongside lib/defines.vh):
  - state encoding IDLE=2'd0, ADDR=2'd1, WAIT=2'd2;
  - owner encoding OWN_INST=1'b0, OWN_DATA=1'b1;
  - the request bundle width constant.
- One sub-module is natural: sram_arb_pick, a combinational grant picker. Inputs: inst_req, data_req, fair flag. Output: grant_valid and grant_owner.

Test Plan:
- Single fetch, zero-wait slave: inst_req=1, inst_addr=0xbfc00000; addr_ok in ADDR; data_ok next cycle with rdata=0x24080001. Expect bus_addr=0xbfc00000, bus_wstrb=0, one inst_ok pulse with inst_rdata=0x24080001, and stallreq_if high until that pulse.
- Contention: inst_req and data_req (load 0x80001000) both high in IDLE. Expect data served first with data_ok, then inst served; bus_addr order 0x80001000 then pc.
- Store with wait states: data_wr=1, data_wen=4'b0011, wdata=0xdeadbeef; addr_ok delayed 3 cycles. Expect bus fields stable across all ADDR cycles, bus_wstrb=4'b0011, data_ok single pulse, and data_rdata unchanged.
- Reset mid-WAIT: drive resetn=0 asynchronously in WAIT. Expect bus_req=0 and ok=0 immediately; after release, IDLE with no spurious ok pulse.
- Spurious bus_data_ok in IDLE/ADDR: no ok pulse and no state change.
- ARB_FAIR_EN: back-to-back data_req with inst_req held. Expect the grant sequence data, inst, data, inst. With the macro undefined, expect data, data, ... while data_req stays high.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// ============================================================================
// Module : sram_bus_arbiter_pkg
// Brief  : Shared types and helpers for the IF/MEM SRAM bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

  // Latched request bundle layout: {wr, wstrb[3:0], addr, wdata}
  localparam int c_REQ_BUNDLE_W = 1 + 4 + 32 + 32;

  function automatic int req_bundle_w(input int addr_w, input int data_w);
    return 1 + 4 + addr_w + data_w;
  endfunction

  function automatic logic [3:0] bus_strobe(input logic wr, input logic [3:0] wen);
    return wr ? wen : 4'b0000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_arb_pick.sv
// ============================================================================
// Module : sram_arb_pick
// Brief  : Combinational grant picker; data wins unless the fairness flag
//          hands the slot to a pending fetch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_pick
  import sram_bus_arbiter_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       fair_flag,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  assign grant_valid = inst_req | data_req;
  assign grant_owner = (data_req && !(fair_flag && inst_req)) ? OWN_DATA : OWN_INST;

endmodule

`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
// ============================================================================
// Module : sram_bus_arbiter
// Brief  : Shares one SRAM-like bus between fetch and data requesters with
//          address/data phase sequencing. Optional macro ARB_FAIR_EN enables
//          alternating grants when both requesters contend.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  localparam int c_BUNDLE_W = req_bundle_w(ADDR_W, DATA_W);

  arb_state_t              r_state;
  arb_owner_t              r_owner;
  logic [c_BUNDLE_W-1:0]   r_bundle;
  logic                    r_bus_req;
  logic                    r_inst_ok;
  logic                    r_data_ok;
  logic [DATA_W-1:0]       r_inst_rdata;
  logic [DATA_W-1:0]       r_data_rdata;

  logic                    w_fair;
  logic                    w_grant_valid;
  arb_owner_t              w_grant_owner;
  logic                    w_grant;
  logic [c_BUNDLE_W-1:0]   w_next_bundle;

  sram_arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .fair_flag   (w_fair),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  // No grant during an ok cycle: the finishing requester may still show req.
  assign w_grant = (r_state == IDLE) && w_grant_valid && !r_inst_ok && !r_data_ok;

  assign w_next_bundle = (w_grant_owner == OWN_DATA)
                       ? {data_wr, bus_strobe(data_wr, data_wen), data_addr, data_wdata}
                       : {1'b0, 4'b0000, inst_addr, {DATA_W{1'b0}}};

`ifdef ARB_FAIR_EN
  logic r_fair;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fair <= 1'b0;
    end else if (w_grant) begin
      if (w_grant_owner == OWN_INST) begin
        r_fair <= 1'b0;
      end else if (inst_req) begin
        r_fair <= 1'b1;
      end
    end
  end

  assign w_fair = r_fair;
`else
  assign w_fair = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_owner      <= OWN_INST;
      r_bundle     <= '0;
      r_bus_req    <= 1'b0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_inst_ok <= 1'b0;
      r_data_ok <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner   <= w_grant_owner;
            r_bundle  <= w_next_bundle;
            r_bus_req <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            r_bus_req <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            r_state <= IDLE;
            if (r_owner == OWN_INST) begin
              r_inst_ok    <= 1'b1;
              r_inst_rdata <= bus_rdata;
            end else begin
              r_data_ok <= 1'b1;
              // Stores only acknowledge; the load result register is kept.
              if (!bus_wr) begin
                r_data_rdata <= bus_rdata;
              end
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign {bus_wr, bus_wstrb, bus_addr, bus_wdata} = r_bundle;
  assign bus_req      = r_bus_req;
  assign inst_ok      = r_inst_ok;
  assign data_ok      = r_data_ok;
  assign inst_rdata   = r_inst_rdata;
  assign data_rdata   = r_data_rdata;
  assign stallreq_if  = inst_req & ~r_inst_ok;
  assign stallreq_mem = data_req & ~r_data_ok;

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
// ============================================================================
// Module : tb_sram_bus_arbiter
// Brief  : Directed self-checking bench for sram_bus_arbiter with an
//          expected-transfer queue. Honours ARB_FAIR_EN for grant order.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_ok      (inst_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_ok      (data_ok),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        own;       // 0 = fetch, 1 = data
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slave_rd;  // value the bench slave returns
    logic [31:0] exp_rd;    // value the owner's rdata must show at ok
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t_req;
  int          t_ok;
  logic [31:0] last_drd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic own, input logic wr, input logic [3:0] strb,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] srd, input logic [31:0] erd);
    exp_t e;
    e.own = own; e.wr = wr; e.wstrb = strb; e.addr = addr;
    e.wdata = wd; e.slave_rd = srd; e.exp_rd = erd;
    sb.push_back(e);
  endtask

  // Act as the slave for one transfer and check it against the queue head.
  task automatic serve(input int addr_wait, input bit spur, input bit drop);
    exp_t e;
    int   n;
    n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bus_req_rise", bus_req, 1);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_empty observed=transfer expected=none");
      return;
    end
    e = sb.pop_front();
    chk("bus_addr", bus_addr, e.addr);
    chk("bus_wr", bus_wr, e.wr);
    chk("bus_wstrb", bus_wstrb, e.wstrb);
    if (e.wr) chk("bus_wdata", bus_wdata, e.wdata);
    chk("stall_busy", e.own ? stallreq_mem : stallreq_if, 1);
    for (int i = 0; i < addr_wait; i++) begin
      bus_data_ok = spur;
      bus_rdata   = 32'hbad00000 | i;
      @(negedge clk);
      chk("addr_hold_req", bus_req, 1);
      chk("addr_hold_addr", bus_addr, e.addr);
      chk("addr_hold_strb", bus_wstrb, e.wstrb);
      if (e.wr) chk("addr_hold_wdata", bus_wdata, e.wdata);
      chk("no_early_ok", {inst_ok, data_ok}, 0);
    end
    bus_data_ok = 1'b0;
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    chk("req_drop", bus_req, 0);
    bus_data_ok = 1'b1;
    bus_rdata   = e.slave_rd;
    @(negedge clk);
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    chk("ok_pulse", e.own ? data_ok : inst_ok, 1);
    chk("ok_other", e.own ? inst_ok : data_ok, 0);
    chk("rdata", e.own ? data_rdata : inst_rdata, e.exp_rd);
    chk("stall_clear", e.own ? stallreq_mem : stallreq_if, 0);
    t_ok = cyc;
    if (drop) begin
      if (e.own) data_req = 1'b0;
      else       inst_req = 1'b0;
    end
    @(negedge clk);
    chk("ok_single", {inst_ok, data_ok}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_wen = '0; data_addr = '0; data_wdata = '0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0; bus_rdata = '0; last_drd = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_ctl", {bus_req, bus_wr, bus_wstrb}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_ok", {inst_ok, data_ok}, 0);
    chk("rst_rdata", {inst_rdata, data_rdata}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single fetch, zero-wait slave
    inst_addr = 32'hbfc00000;
    inst_req  = 1'b1;
    t_req     = cyc;
    push(1'b0, 1'b0, 4'h0, 32'hbfc00000, 32'h0, 32'h24080001, 32'h24080001);
    serve(0, 1'b0, 1'b1);
    chk("fetch_latency", t_ok - t_req, 3);

    // Contention: data first, then fetch
    data_addr = 32'h80001000; data_wr = 1'b0; data_wen = 4'hf; data_req = 1'b1;
    inst_addr = 32'hbfc00004; inst_req = 1'b1;
    push(1'b1, 1'b0, 4'h0, 32'h80001000, 32'h0, 32'h11112222, 32'h11112222);
    last_drd = 32'h11112222;
    push(1'b0, 1'b0, 4'h0, 32'hbfc00004, 32'h0, 32'h3c1d0000, 32'h3c1d0000);
    serve(0, 1'b0, 1'b1);
    serve(0, 1'b0, 1'b1);

    // Store with three address wait states
    data_wr = 1'b1; data_wen = 4'b0011; data_addr = 32'h80002000;
    data_wdata = 32'hdeadbeef; data_req = 1'b1;
    push(1'b1, 1'b1, 4'b0011, 32'h80002000, 32'hdeadbeef, 32'hfeedface, last_drd);
    serve(3, 1'b0, 1'b1);

    // Spurious data_ok in IDLE
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h77777777;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_spur_ok", {inst_ok, data_ok}, 0);
      chk("idle_spur_req", bus_req, 0);
    end
    bus_data_ok = 1'b0;

    // Spurious data_ok during ADDR on a load
    data_wr = 1'b0; data_addr = 32'h80003000; data_req = 1'b1;
    push(1'b1, 1'b0, 4'h0, 32'h80003000, 32'h0, 32'h55aa55aa, 32'h55aa55aa);
    last_drd = 32'h55aa55aa;
    serve(2, 1'b1, 1'b1);

    // Asynchronous reset while in WAIT
    inst_addr = 32'hbfc00008;
    inst_req  = 1'b1;
    n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_req_rise", bus_req, 1);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h99999999;
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_req", bus_req, 0);
    chk("rst_async_ok", {inst_ok, data_ok}, 0);
    chk("rst_async_rdata", inst_rdata, 0);
    chk("rst_async_addr", bus_addr, 0);
    inst_req    = 1'b0;
    bus_data_ok = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ok", {inst_ok, data_ok}, 0);
      chk("post_rst_req", bus_req, 0);
    end

    // Back-to-back data with fetch held
    inst_addr = 32'hbfc00010; inst_req = 1'b1;
    data_addr = 32'h80004000; data_wr = 1'b0; data_req = 1'b1;
`ifdef ARB_FAIR_EN
    push(1'b1, 1'b0, 4'h0, 32'h80004000, 32'h0, 32'ha0000001, 32'ha0000001);
    push(1'b0, 1'b0, 4'h0, 32'hbfc00010, 32'h0, 32'hb0000001, 32'hb0000001);
    push(1'b1, 1'b0, 4'h0, 32'h80004000, 32'h0, 32'ha0000002, 32'ha0000002);
    push(1'b0, 1'b0, 4'h0, 32'hbfc00010, 32'h0, 32'hb0000002, 32'hb0000002);
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b1);
    data_req = 1'b0;
`else
    push(1'b1, 1'b0, 4'h0, 32'h80004000, 32'h0, 32'ha0000001, 32'ha0000001);
    push(1'b1, 1'b0, 4'h0, 32'h80004000, 32'h0, 32'ha0000002, 32'ha0000002);
    push(1'b1, 1'b0, 4'h0, 32'h80004000, 32'h0, 32'ha0000003, 32'ha0000003);
    push(1'b0, 1'b0, 4'h0, 32'hbfc00010, 32'h0, 32'hb0000001, 32'hb0000001);
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b1);
    serve(0, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("final_idle_req", bus_req, 0);
    end
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
